// File: rtl/arb_requester.sv
// Per-channel burst requester in front of an external fixed-priority arbiter.
// Optional per-channel starvation counters are enabled with ARB_REQUESTER_STARVE_EN.
module arb_requester #(
   parameter int NCH        = 4,
   parameter int LEN_W      = 4,
   parameter int STARVE_LIM = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [NCH-1:0]       cmd_valid,
   output logic [NCH-1:0]       cmd_ready,
   input  logic [NCH*LEN_W-1:0] cmd_len,
   output logic [NCH-1:0]       req,
   input  logic [NCH-1:0]       gnt,
   output logic [NCH-1:0]       beat,
   output logic [NCH-1:0]       done,
   output logic                 busy,
   output logic                 gnt_err,
   output logic [NCH-1:0]       starve
);

   // cmd_valid/cmd_ready: a command transfers on a cycle where both are high;
   // ready is high exactly while the channel is IDLE. req/gnt: req is registered,
   // gnt is the same-cycle answer and only a lone grant on a requesting channel counts.

   localparam logic [0:0] S_IDLE = 1'b0;
   localparam logic [0:0] S_REQ  = 1'b1;
   localparam int         RW     = LEN_W + 1;

   if (STARVE_LIM < 1) begin : g_bad_lim
      $error("STARVE_LIM must be at least 1");
   end

   logic [0:0]    state_q [NCH];
   logic [0:0]    state_d [NCH];
   logic [RW-1:0] rem_q   [NCH];
   logic [RW-1:0] rem_d   [NCH];
   logic          gnt_multi;
   logic          gnt_stray;
   logic [NCH-1:0] gnt_ok;
   logic [LEN_W-1:0] len_i;

   assign gnt_multi = (gnt & (gnt - NCH'(1))) != '0;
   assign gnt_stray = (gnt & ~req) != '0;
   // A multi-hot grant voids every bit; a stray bit is simply masked by req.
   assign gnt_ok    = (rst || gnt_multi) ? '0 : (gnt & req);
   assign gnt_err   = !rst && (gnt_multi || gnt_stray);
   assign beat      = gnt_ok;
   assign busy      = |req;

   always_comb begin
      len_i = '0;
      for (int i = 0; i < NCH; i++) begin
         state_d[i]   = state_q[i];
         rem_d[i]     = rem_q[i];
         req[i]       = (state_q[i] == S_REQ);
         cmd_ready[i] = (state_q[i] == S_IDLE);
         done[i]      = gnt_ok[i] && (rem_q[i] == RW'(1));
         len_i        = cmd_len[i*LEN_W +: LEN_W];
         case (state_q[i])
            S_IDLE: begin
               if (cmd_valid[i]) begin
                  state_d[i] = S_REQ;
                  // Length 0 stands for the full 2**LEN_W beats.
                  rem_d[i]   = (len_i == '0) ? {1'b1, {LEN_W{1'b0}}} : {1'b0, len_i};
               end
            end
            S_REQ: begin
               if (gnt_ok[i]) begin
                  rem_d[i] = rem_q[i] - RW'(1);
                  if (rem_q[i] == RW'(1)) state_d[i] = S_IDLE;
               end
            end
            default: state_d[i] = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      for (int i = 0; i < NCH; i++) begin
         if (rst) begin
            state_q[i] <= S_IDLE;
            rem_q[i]   <= '0;
         end else begin
            state_q[i] <= state_d[i];
            rem_q[i]   <= rem_d[i];
         end
      end
   end

`ifdef ARB_REQUESTER_STARVE_EN
   localparam int CW = $clog2(STARVE_LIM + 1);

   logic [CW-1:0] wait_q [NCH];
   logic [CW-1:0] wait_d [NCH];

   // Saturating wait count; any accepted grant or leaving REQ clears it.
   always_comb begin
      for (int i = 0; i < NCH; i++) begin
         wait_d[i] = '0;
         if (state_q[i] == S_REQ && !gnt_ok[i]) begin
            wait_d[i] = (wait_q[i] >= CW'(STARVE_LIM)) ? wait_q[i] : wait_q[i] + CW'(1);
         end
         starve[i] = (wait_q[i] >= CW'(STARVE_LIM));
      end
   end

   always_ff @(posedge clk) begin
      for (int i = 0; i < NCH; i++) begin
         if (rst) wait_q[i] <= '0;
         else     wait_q[i] <= wait_d[i];
      end
   end
`else
   assign starve = '0;
`endif

endmodule

// File: tb/tb_arb_requester.sv
// Directed bench for arb_requester: vector table for burst/arbitration flows,
// hand sequences for long bursts, reset abort and starvation.
module tb_arb_requester;

   logic        clk;
   logic        rst;
   logic [3:0]  cmd_valid;
   logic [3:0]  cmd_ready;
   logic [15:0] cmd_len;
   logic [3:0]  req;
   logic [3:0]  gnt;
   logic [3:0]  beat;
   logic [3:0]  done;
   logic        busy;
   logic        gnt_err;
   logic [3:0]  starve;

   int n_cmp;
   int n_fail;

   typedef struct {
      logic [3:0]  valid;
      logic [15:0] len;
      logic [3:0]  gnt;
      logic [3:0]  e_req;
      logic [3:0]  e_rdy;
      logic [3:0]  e_beat;
      logic [3:0]  e_done;
      logic        e_busy;
      logic        e_err;
   } vec_t;

   vec_t vecs[$];

   arb_requester #(.NCH(4), .LEN_W(4), .STARVE_LIM(16)) dut (
      .clk       (clk),
      .rst       (rst),
      .cmd_valid (cmd_valid),
      .cmd_ready (cmd_ready),
      .cmd_len   (cmd_len),
      .req       (req),
      .gnt       (gnt),
      .beat      (beat),
      .done      (done),
      .busy      (busy),
      .gnt_err   (gnt_err),
      .starve    (starve)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, expected end of test");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic add(input logic [3:0] v, input logic [15:0] l, input logic [3:0] g,
                      input logic [3:0] r, input logic [3:0] rd, input logic [3:0] b,
                      input logic [3:0] d, input logic bz, input logic e);
      vec_t t;
      t.valid = v; t.len = l; t.gnt = g;
      t.e_req = r; t.e_rdy = rd; t.e_beat = b; t.e_done = d; t.e_busy = bz; t.e_err = e;
      vecs.push_back(t);
   endtask

   task automatic drive(input logic r, input logic [3:0] v, input logic [15:0] l,
                        input logic [3:0] g);
      @(negedge clk);
      rst = r; cmd_valid = v; cmd_len = l; gnt = g;
      #1;
   endtask

   task automatic chk_all(input string tag, input logic [3:0] r, input logic [3:0] rd,
                          input logic [3:0] b, input logic [3:0] d, input logic bz,
                          input logic e);
      chk({tag, ".req"},     32'(req),       32'(r));
      chk({tag, ".ready"},   32'(cmd_ready), 32'(rd));
      chk({tag, ".beat"},    32'(beat),      32'(b));
      chk({tag, ".done"},    32'(done),      32'(d));
      chk({tag, ".busy"},    32'(busy),      32'(bz));
      chk({tag, ".gnt_err"}, 32'(gnt_err),   32'(e));
   endtask

   initial begin
      int beats;
      int dones;
      int done_at;
      logic [3:0] exp_st;

      n_cmp = 0; n_fail = 0;
      rst = 1'b1; cmd_valid = '0; cmd_len = '0; gnt = '0;

      // reset: outputs quiet even with a stray grant present
      @(posedge clk);
      drive(1'b1, 4'h0, 16'h0, 4'hf);
      chk_all("reset", 4'h0, 4'hf, 4'h0, 4'h0, 1'b0, 1'b0);
      chk("reset.starve", 32'(starve), 32'h0);
      drive(1'b0, 4'h0, 16'h0, 4'h0);
      chk_all("post_reset", 4'h0, 4'hf, 4'h0, 4'h0, 1'b0, 1'b0);

      // ch0 burst of 3 with gnt following req
      add(4'h1, 16'h0003, 4'h0, 4'h0, 4'hf, 4'h0, 4'h0, 1'b0, 1'b0);
      add(4'h0, 16'h0000, 4'h1, 4'h1, 4'he, 4'h1, 4'h0, 1'b1, 1'b0);
      add(4'h0, 16'h0000, 4'h1, 4'h1, 4'he, 4'h1, 4'h0, 1'b1, 1'b0);
      add(4'h0, 16'h0000, 4'h1, 4'h1, 4'he, 4'h1, 4'h1, 1'b1, 1'b0);
      add(4'h0, 16'h0000, 4'h0, 4'h0, 4'hf, 4'h0, 4'h0, 1'b0, 1'b0);
      // illegal grants: multi-hot, then grant to an idle channel; bursts stay intact
      add(4'h3, 16'h0044, 4'h0, 4'h0, 4'hf, 4'h0, 4'h0, 1'b0, 1'b0);
      add(4'h0, 16'h0000, 4'h3, 4'h3, 4'hc, 4'h0, 4'h0, 1'b1, 1'b1);
      add(4'h0, 16'h0000, 4'h4, 4'h3, 4'hc, 4'h0, 4'h0, 1'b1, 1'b1);
      for (int k = 0; k < 3; k++) add(4'h0, 16'h0, 4'h1, 4'h3, 4'hc, 4'h1, 4'h0, 1'b1, 1'b0);
      add(4'h0, 16'h0000, 4'h1, 4'h3, 4'hc, 4'h1, 4'h1, 1'b1, 1'b0);
      for (int k = 0; k < 3; k++) add(4'h0, 16'h0, 4'h2, 4'h2, 4'hd, 4'h2, 4'h0, 1'b1, 1'b0);
      add(4'h0, 16'h0000, 4'h2, 4'h2, 4'hd, 4'h2, 4'h2, 1'b1, 1'b0);
      add(4'h0, 16'h0000, 4'h0, 4'h0, 4'hf, 4'h0, 4'h0, 1'b0, 1'b0);
      // four channels of 2 beats under fixed priority, bit 0 highest
      add(4'hf, 16'h2222, 4'h0, 4'h0, 4'hf, 4'h0, 4'h0, 1'b0, 1'b0);
      add(4'h0, 16'h0000, 4'h1, 4'hf, 4'h0, 4'h1, 4'h0, 1'b1, 1'b0);
      add(4'h0, 16'h0000, 4'h1, 4'hf, 4'h0, 4'h1, 4'h1, 1'b1, 1'b0);
      add(4'h0, 16'h0000, 4'h2, 4'he, 4'h1, 4'h2, 4'h0, 1'b1, 1'b0);
      add(4'h0, 16'h0000, 4'h2, 4'he, 4'h1, 4'h2, 4'h2, 1'b1, 1'b0);
      add(4'h0, 16'h0000, 4'h4, 4'hc, 4'h3, 4'h4, 4'h0, 1'b1, 1'b0);
      add(4'h0, 16'h0000, 4'h4, 4'hc, 4'h3, 4'h4, 4'h4, 1'b1, 1'b0);
      add(4'h0, 16'h0000, 4'h8, 4'h8, 4'h7, 4'h8, 4'h0, 1'b1, 1'b0);
      add(4'h0, 16'h0000, 4'h8, 4'h8, 4'h7, 4'h8, 4'h8, 1'b1, 1'b0);
      add(4'h0, 16'h0000, 4'h0, 4'h0, 4'hf, 4'h0, 4'h0, 1'b0, 1'b0);

      foreach (vecs[n]) begin
         drive(1'b0, vecs[n].valid, vecs[n].len, vecs[n].gnt);
         chk_all($sformatf("vec%0d", n), vecs[n].e_req, vecs[n].e_rdy, vecs[n].e_beat,
                 vecs[n].e_done, vecs[n].e_busy, vecs[n].e_err);
         chk($sformatf("vec%0d.starve", n), 32'(starve), 32'h0);
      end

      // ch2 with length 0 means 16 beats
      drive(1'b0, 4'h4, 16'h0000, 4'h0);
      beats = 0; dones = 0; done_at = 0;
      for (int k = 0; k < 20; k++) begin
         drive(1'b0, 4'h0, 16'h0000, req & 4'h4);
         if (beat[2]) beats++;
         if (done[2]) begin dones++; done_at = beats; end
      end
      chk("len0.beats", 32'(beats), 32'd16);
      chk("len0.dones", 32'(dones), 32'd1);
      chk("len0.done_on_last", 32'(done_at), 32'd16);
      chk("len0.req_after", 32'(req), 32'h0);

      // ch1 burst of 5 aborted by reset after 2 beats
      drive(1'b0, 4'h2, 16'h0050, 4'h0);
      for (int k = 0; k < 2; k++) begin
         drive(1'b0, 4'h0, 16'h0000, 4'h2);
         chk($sformatf("abort.beat%0d", k), 32'(beat), 32'h2);
         chk($sformatf("abort.done%0d", k), 32'(done), 32'h0);
      end
      drive(1'b1, 4'h0, 16'h0000, 4'h2);
      chk_all("abort.in_reset", 4'h2, 4'hd, 4'h0, 4'h0, 1'b1, 1'b0);
      drive(1'b0, 4'h0, 16'h0000, 4'h0);
      chk_all("abort.after", 4'h0, 4'hf, 4'h0, 4'h0, 1'b0, 1'b0);
      for (int k = 0; k < 3; k++) begin
         drive(1'b0, 4'h0, 16'h0000, 4'h0);
         chk($sformatf("abort.quiet%0d", k), 32'({req, done}), 32'h0);
      end
      // fresh single-beat command after the abort
      drive(1'b0, 4'h2, 16'h0010, 4'h0);
      drive(1'b0, 4'h0, 16'h0000, 4'h2);
      chk_all("abort.fresh", 4'h2, 4'hd, 4'h2, 4'h2, 1'b1, 1'b0);
      drive(1'b0, 4'h0, 16'h0000, 4'h0);
      chk("abort.fresh_end", 32'(req), 32'h0);

      // ch3 starved for 16 cycles, then one grant
      drive(1'b0, 4'h8, 16'h2000, 4'h0);
      for (int k = 0; k <= 16; k++) begin
         drive(1'b0, 4'h0, 16'h0000, 4'h0);
`ifdef ARB_REQUESTER_STARVE_EN
         exp_st = (k >= 16) ? 4'h8 : 4'h0;
`else
         exp_st = 4'h0;
`endif
         chk($sformatf("starve.wait%0d", k), 32'(starve), 32'(exp_st));
      end
      drive(1'b0, 4'h0, 16'h0000, 4'h8);
      chk("starve.grant_beat", 32'(beat), 32'h8);
`ifdef ARB_REQUESTER_STARVE_EN
      chk("starve.at_grant", 32'(starve), 32'h8);
`else
      chk("starve.at_grant", 32'(starve), 32'h0);
`endif
      drive(1'b0, 4'h0, 16'h0000, 4'h8);
      chk("starve.cleared", 32'(starve), 32'h0);
      chk("starve.done", 32'(done), 32'h8);
      drive(1'b0, 4'h0, 16'h0000, 4'h0);
      chk_all("starve.end", 4'h0, 4'hf, 4'h0, 4'h0, 1'b0, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
